// File: rtl/npc_pkg.sv
// Shared NPC core definitions: register-file defaults, clear FSM states, address width helper.
package npc_pkg;

    localparam int unsigned XLEN_DEF = 64;
    localparam int unsigned NREG_DEF = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_e;

    // Address width for n entries, never below one bit.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, flush clears all.
module regfile_sb_scoreboard
    import npc_pkg::*;
#(
    parameter int unsigned NREG     = NREG_DEF,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = addr_width(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_run,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic              i_iss_en,
    input  logic [AW-1:0]     i_iss_rd,
    input  logic              i_flush,
    input  logic [NRD*AW-1:0] i_rd_addr,
    output logic [NRD-1:0]    o_rd_busy
);

    localparam bit ZR = (ZERO_REG != 0);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Set after clear so a same-cycle reissue keeps the register busy for the newer producer.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_run) begin
            if (i_flush) begin
                w_busy_nxt = '0;
            end else begin
                if (i_wr_en) begin
                    w_busy_nxt[i_wr_addr] = 1'b0;
                end
                if (i_iss_en) begin
                    w_busy_nxt[i_iss_rd] = 1'b1;
                end
            end
        end
        if (ZR) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    always_comb begin
        o_rd_busy = '0;
        for (int i = 0; i < int'(NRD); i++) begin
            o_rd_busy[i] = r_busy[i_rd_addr[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with N bypassed read ports, post-reset hardware clear and busy scoreboard.
module regfile_sb
    import npc_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREG     = NREG_DEF,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = addr_width(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic                init_done,
    input  logic [AW-1:0]       dbg_addr1,
    input  logic [AW-1:0]       dbg_addr2,
    output logic [XLEN-1:0]     dbg_data1,
    output logic [XLEN-1:0]     dbg_data2
);

    localparam bit ZR = (ZERO_REG != 0);

    rf_state_e       r_state;
    rf_state_e       w_state_nxt;
    logic [AW-1:0]   r_clr_idx;
    logic [AW-1:0]   w_clr_idx_nxt;
    logic            w_run;
    logic            w_clr_we;
    logic            w_wr_we;
    logic [XLEN-1:0] r_rf [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // Clear walks every register once, then hands over to normal operation.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_run         = 1'b0;
        w_clr_we      = 1'b0;
        w_wr_we       = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_we      = 1'b1;
                w_clr_idx_nxt = r_clr_idx + AW'(1);
                if (r_clr_idx == AW'(NREG - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run   = 1'b1;
                w_wr_we = wr_en && !(ZR && (wr_addr == '0));
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clr_we) begin
                r_rf[r_clr_idx] <= '0;
            end else if (w_wr_we) begin
                r_rf[wr_addr] <= wr_data;
            end
        end
    end

    assign init_done = w_run;

    // Operand reads bypass the same-cycle writeback; nothing is visible during clear.
    always_comb begin
        logic [AW-1:0] a;
        a       = '0;
        rd_data = '0;
        for (int i = 0; i < int'(NRD); i++) begin
            a = rd_addr[i*AW +: AW];
            if (w_run && !(ZR && (a == '0))) begin
                rd_data[i*XLEN +: XLEN] = (wr_en && (wr_addr == a)) ? wr_data : r_rf[a];
            end
        end
    end

    assign dbg_data1 = (w_run && !(ZR && (dbg_addr1 == '0))) ? r_rf[dbg_addr1] : '0;
    assign dbg_data2 = (w_run && !(ZR && (dbg_addr2 == '0))) ? r_rf[dbg_addr2] : '0;

    regfile_sb_scoreboard #(
        .NREG     (NREG),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .i_run     (w_run),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_iss_en  (iss_en),
        .i_iss_rd  (iss_rd),
        .i_flush   (flush),
        .i_rd_addr (rd_addr),
        .o_rd_busy (rd_busy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed stimulus for regfile_sb, scoreboard-checked against a behavioural model.
module tb_regfile_sb;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned AW   = $clog2(NREG);

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_rd;
    logic                flush;
    logic                init_done;
    logic [AW-1:0]       dbg_addr1;
    logic [AW-1:0]       dbg_addr2;
    logic [XLEN-1:0]     dbg_data1;
    logic [XLEN-1:0]     dbg_data2;

    regfile_sb #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .NRD      (NRD),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_en    (iss_en),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .init_done (init_done),
        .dbg_addr1 (dbg_addr1),
        .dbg_addr2 (dbg_addr2),
        .dbg_data1 (dbg_data1),
        .dbg_data2 (dbg_data2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NRD*XLEN-1:0] rd;
        logic [NRD-1:0]      busy;
        logic [XLEN-1:0]     d1;
        logic [XLEN-1:0]     d2;
        logic                done;
    } exp_t;

    exp_t q[$];

    // Behavioural model: register contents, busy set, clear progress.
    logic [XLEN-1:0] m_rf [NREG];
    bit              m_busy [NREG];
    bit              m_run = 1'b0;
    int              m_clr = 0;

    int  n_vec = 0;
    int  n_err = 0;
    bit  end_chk = 1'b0;
    bit  end_done = 1'b0;

    task automatic chk(input string nm, input logic [NRD*XLEN-1:0] act, input logic [NRD*XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: one expected response per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("init_done", {{(NRD*XLEN-1){1'b0}}, init_done}, {{(NRD*XLEN-1){1'b0}}, e.done});
            chk("rd_data", rd_data, e.rd);
            chk("rd_busy", {{(NRD*XLEN-NRD){1'b0}}, rd_busy}, {{(NRD*XLEN-NRD){1'b0}}, e.busy});
            chk("dbg_data1", {{(NRD*XLEN-XLEN){1'b0}}, dbg_data1}, {{(NRD*XLEN-XLEN){1'b0}}, e.d1});
            chk("dbg_data2", {{(NRD*XLEN-XLEN){1'b0}}, dbg_data2}, {{(NRD*XLEN-XLEN){1'b0}}, e.d2});
        end else if (end_chk && !end_done) begin
            end_done = 1'b1;
            chk("queue_drained", (NRD*XLEN)'(q.size()), '0);
        end
    end

    // Record expected outputs for the current inputs, advance the model, move to the next cycle.
    task automatic tick();
        exp_t e;
        int a;
        e.done = m_run;
        e.rd   = '0;
        e.busy = '0;
        for (int i = 0; i < int'(NRD); i++) begin
            a = int'(rd_addr[i*AW +: AW]);
            if (m_run) begin
                if (a != 0) e.rd[i*XLEN +: XLEN] = (wr_en && int'(wr_addr) == a) ? wr_data : m_rf[a];
                e.busy[i] = m_busy[a];
            end
        end
        e.d1 = (m_run && dbg_addr1 != 0) ? m_rf[dbg_addr1] : '0;
        e.d2 = (m_run && dbg_addr2 != 0) ? m_rf[dbg_addr2] : '0;
        q.push_back(e);

        if (rst) begin
            m_run = 1'b0;
            m_clr = 0;
            for (int r = 0; r < int'(NREG); r++) m_busy[r] = 1'b0;
        end else if (!m_run) begin
            m_rf[m_clr] = '0;
            m_clr++;
            if (m_clr == int'(NREG)) m_run = 1'b1;
        end else begin
            if (wr_en && wr_addr != 0) m_rf[wr_addr] = wr_data;
            if (flush) begin
                for (int r = 0; r < int'(NREG); r++) m_busy[r] = 1'b0;
            end else begin
                if (wr_en) m_busy[wr_addr] = 1'b0;
                if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst    = 1'b0;
        wr_en  = 1'b0;
        iss_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic rnd(input bit rst_ok);
        rst       = rst_ok && ($urandom_range(63) == 0);
        wr_en     = $urandom_range(1);
        wr_addr   = AW'($urandom);
        wr_data   = {$urandom, $urandom};
        iss_en    = $urandom_range(1);
        iss_rd    = AW'($urandom);
        flush     = ($urandom_range(15) == 0);
        rd_addr   = (NRD*AW)'({$urandom, $urandom});
        dbg_addr1 = AW'($urandom);
        dbg_addr2 = AW'($urandom);
        // Bias operand reads toward the write address to exercise the bypass.
        if ($urandom_range(3) == 0) set_rd(int'($urandom_range(NRD - 1)), int'(wr_addr));
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_rd = '0;
        flush = 1'b0; rd_addr = '0; dbg_addr1 = '0; dbg_addr2 = '0;
        @(posedge clk);
        #1;

        // Power-on clear with writes, issues and flushes that must be ignored.
        repeat (3) begin rnd(1'b0); rst = 1'b1; tick(); end
        repeat (34) begin rnd(1'b0); tick(); end

        // Preload garbage, then clear again while sweeping debug reads.
        repeat (100) begin rnd(1'b0); tick(); end
        idle(); rst = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 36; k++) begin
            rnd(1'b0);
            dbg_addr1 = AW'(k);
            tick();
        end

        // Same-cycle bypass versus non-bypassed debug port.
        idle(); wr_en = 1'b1; wr_addr = AW'(5); wr_data = 64'hDEADBEEF_00000001;
        set_rd(0, 5); dbg_addr1 = AW'(5);
        tick();
        idle(); tick();

        // Register zero ignores writes and allocation.
        idle(); wr_en = 1'b1; wr_addr = '0; wr_data = 64'h1234; iss_en = 1'b1; iss_rd = '0;
        rd_addr = '0; dbg_addr1 = '0; dbg_addr2 = '0;
        tick();
        idle(); repeat (3) tick();

        // Allocation wins over a same-cycle release.
        idle(); set_rd(0, 7); set_rd(1, 7); iss_en = 1'b1; iss_rd = AW'(7);
        tick();
        idle(); tick(); tick();
        wr_en = 1'b1; wr_addr = AW'(7); wr_data = 64'h77; iss_en = 1'b1; iss_rd = AW'(7);
        tick();
        idle(); tick();
        wr_en = 1'b1; wr_addr = AW'(7); wr_data = 64'h78;
        tick();
        idle(); tick();

        // Flush clears everything and suppresses a concurrent allocation.
        for (int r = 1; r <= 3; r++) begin
            idle(); iss_en = 1'b1; iss_rd = AW'(r); set_rd(0, r);
            tick();
        end
        idle(); flush = 1'b1; iss_en = 1'b1; iss_rd = AW'(4);
        tick();
        idle(); set_rd(0, 1); set_rd(1, 2); tick();
        set_rd(0, 3); set_rd(1, 4); tick();

        // Reset in the middle of operation.
        idle(); wr_en = 1'b1; wr_addr = AW'(9); wr_data = 64'h55; tick();
        idle(); iss_en = 1'b1; iss_rd = AW'(9); tick();
        idle(); set_rd(0, 9); dbg_addr1 = AW'(9); tick();
        rst = 1'b1; tick();
        idle(); repeat (34) tick();

        // Long random run with occasional resets.
        repeat (800) begin rnd(1'b1); tick(); end
        idle(); tick();

        end_chk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
